csr_file_m: RTL and testbench

//  Parametrised machine-mode CSR file for the pipelined RV32 core, sitting beside the writeback/commit stage.

---
 rtl/csr_if.sv | 11 +
 rtl/csr_file_m.sv | 117 +++++++++++
 tb/tb_csr_file_m.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/csr_if.sv
// csr_if: CSR access port between the commit stage and the CSR file.
interface csr_if #(parameter int XLEN = 32);
    logic            valid;
    logic [2:0]      op;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            illegal;
    modport master(output valid, op, addr, wdata, input rdata, illegal);
    modport slave(input valid, op, addr, wdata, output rdata, illegal);
endinterface

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with 64-bit counters, interrupt entry and mret redirect.
module csr_file_m #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
    parameter int              HAS_COUNTERS = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    csr_if.slave            bus,
    input  logic            t_intr_i,
    input  logic            e_intr_i,
    input  logic            sw_intr_i,
    input  logic            intr_ready_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            retire_i,
    input  logic            mret_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);
    localparam int CW = 2 * XLEN;
    localparam logic [XLEN-1:0] LOW2 = XLEN'(3);
    logic            mst_mie, mst_mpie, addr_ok, wr, take;
    logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [CW-1:0]   mcycle_q, minstret_q;
    logic [XLEN-1:0] mip_v, mstatus_v, old_v, new_v, pend, base, trap_pc;
    logic [3:0]      code;
    always_comb begin
        mip_v          = '0;
        mip_v[3]       = sw_intr_i;
        mip_v[7]       = t_intr_i;
        mip_v[11]      = e_intr_i;
        mstatus_v      = '0;
        mstatus_v[12:11] = 2'b11;
        mstatus_v[7]   = mst_mpie;
        mstatus_v[3]   = mst_mie;
        addr_ok        = 1'b1;
        case (bus.addr)
            12'h300: old_v = mstatus_v;
            12'h304: old_v = mie_q;
            12'h305: old_v = mtvec_q;
            12'h340: old_v = mscratch_q;
            12'h341: old_v = mepc_q;
            12'h342: old_v = mcause_q;
            12'h344: old_v = mip_v;
            12'hB00: old_v = mcycle_q[XLEN-1:0];
            12'hB80: old_v = mcycle_q[CW-1:XLEN];
            12'hB02: old_v = minstret_q[XLEN-1:0];
            12'hB82: old_v = minstret_q[CW-1:XLEN];
            default: begin
                old_v   = '0;
                addr_ok = 1'b0;
            end
        endcase
    end
    assign bus.illegal = bus.valid && (!addr_ok || bus.op inside {3'b000, 3'b100});
    assign bus.rdata   = bus.valid ? old_v : '0;
    assign new_v = bus.op[1:0] == 2'b01 ? bus.wdata :
                   bus.op[1:0] == 2'b10 ? (old_v | bus.wdata) : (old_v & ~bus.wdata);
    assign pend  = mip_v & mie_q;
    assign take  = mst_mie && |pend && intr_ready_i;
    assign code  = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
    // A taken interrupt flushes the committing CSR instruction, so its write is dropped.
    assign wr    = bus.valid && !bus.illegal && !take && (bus.op[1:0] == 2'b01 || |bus.wdata);
    assign base  = mtvec_q & ~LOW2;
    assign trap_pc = mtvec_q[1:0] == 2'b01 ? base + XLEN'({code, 2'b00}) : base;
    assign redirect_o    = take || mret_i;
    assign redirect_pc_o = take ? trap_pc : mret_i ? mepc_q : '0;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (take) begin
            mepc_q   <= pc_i & ~LOW2;
            mcause_q <= {1'b1, (XLEN-1)'(code)};
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
        end else begin
            if (wr) begin
                case (bus.addr)
                    12'h300: begin
                        mst_mie  <= new_v[3];
                        mst_mpie <= new_v[7];
                    end
                    12'h304: mie_q      <= new_v & XLEN'(12'h888);
                    12'h305: mtvec_q    <= new_v[1] ? (new_v & ~LOW2) : new_v;
                    12'h340: mscratch_q <= new_v;
                    12'h341: mepc_q     <= new_v & ~LOW2;
                    12'h342: mcause_q   <= new_v;
                    default: ;
                endcase
            end
            if (mret_i) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end
        end
    end
    // A software write to a counter half replaces the increment for that cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else if (HAS_COUNTERS != 0) begin
            mcycle_q   <= wr && bus.addr == 12'hB00 ? {mcycle_q[CW-1:XLEN], new_v} :
                          wr && bus.addr == 12'hB80 ? {new_v, mcycle_q[XLEN-1:0]} :
                          mcycle_q + CW'(1);
            minstret_q <= wr && bus.addr == 12'hB02 ? {minstret_q[CW-1:XLEN], new_v} :
                          wr && bus.addr == 12'hB82 ? {new_v, minstret_q[XLEN-1:0]} :
                          minstret_q + CW'(retire_i);
        end
    end
endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: directed checks of CSR access, counters, interrupt entry and mret.
module tb_csr_file_m;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        t_intr_i, e_intr_i, sw_intr_i, intr_ready_i, retire_i, mret_i;
    logic [31:0] pc_i, redirect_pc_o, d;
    logic        redirect_o;
    int          errs = 0;
    int          checks = 0;
    csr_if #(.XLEN(32)) bus();
    csr_file_m #(.XLEN(32), .MTVEC_RESET(32'h40), .HAS_COUNTERS(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave),
        .t_intr_i(t_intr_i), .e_intr_i(e_intr_i), .sw_intr_i(sw_intr_i),
        .intr_ready_i(intr_ready_i), .pc_i(pc_i), .retire_i(retire_i), .mret_i(mret_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic csr(input logic [2:0] f, input logic [11:0] a, input logic [31:0] w);
        bus.valid = 1'b1;
        bus.op    = f;
        bus.addr  = a;
        bus.wdata = w;
        #1;
        d = bus.rdata;
        step();
        bus.valid = 1'b0;
    endtask
    task automatic rd(input logic [11:0] a);
        csr(3'b010, a, 32'h0);
    endtask
    initial begin
        rst_i = 1'b1;
        {t_intr_i, e_intr_i, sw_intr_i, intr_ready_i, retire_i, mret_i} = '0;
        pc_i = '0;
        bus.valid = 1'b0; bus.op = '0; bus.addr = '0; bus.wdata = '0;
        #12;
        chk("rst_redirect", 32'(redirect_o), 32'h0);
        chk("rst_redirect_pc", redirect_pc_o, 32'h0);
        chk("rst_illegal", 32'(bus.illegal), 32'h0);
        rst_i = 1'b0;
        step();
        rd(12'h305); chk("rst_mtvec", d, 32'h40);
        rd(12'h300); chk("rst_mstatus", d, 32'h1800);
        rd(12'h342); chk("rst_mcause", d, 32'h0);
        rd(12'hB02); chk("rst_minstret", d, 32'h0);
        csr(3'b001, 12'h305, 32'h1001); chk("mtvec_rw_old", d, 32'h40);
        csr(3'b010, 12'h305, 32'h2);    chk("mtvec_rs_old", d, 32'h1001);
        csr(3'b001, 12'h305, 32'h101);
        rd(12'h305); chk("mtvec_vec", d, 32'h101);
        csr(3'b001, 12'h304, 32'hFFFF_FFFF);
        rd(12'h304); chk("mie_mask", d, 32'h888);
        csr(3'b011, 12'h304, 32'h0);
        rd(12'h304); chk("mie_rc_zero", d, 32'h888);
        csr(3'b001, 12'h304, 32'h80);
        csr(3'b001, 12'h344, 32'hFFFF);
        sw_intr_i = 1'b1;
        rd(12'h344); chk("mip_ro", d, 32'h8);
        sw_intr_i = 1'b0;
        bus.valid = 1'b1; bus.op = 3'b001; bus.addr = 12'h7C0; bus.wdata = 32'h1;
        #1;
        chk("illegal_addr", 32'(bus.illegal), 32'h1);
        bus.addr = 12'h340; bus.op = 3'b100;
        #1;
        chk("illegal_op", 32'(bus.illegal), 32'h1);
        step();
        bus.valid = 1'b0;
        csr(3'b001, 12'h340, 32'hDEAD_BEEF);
        csr(3'b110, 12'h340, 32'h0);
        rd(12'h340); chk("mscratch", d, 32'hDEAD_BEEF);
        csr(3'b001, 12'h341, 32'h207);
        rd(12'h341); chk("mepc_align", d, 32'h204);
        csr(3'b001, 12'h300, 32'hFFFF_FF77);
        rd(12'h300); chk("mstatus_fields", d, 32'h1800);
        csr(3'b001, 12'h300, 32'h8);
        rd(12'h300); chk("mstatus_mie", d, 32'h1808);
        t_intr_i = 1'b1; pc_i = 32'h200;
        #1;
        chk("no_take_not_ready", 32'(redirect_o), 32'h0);
        intr_ready_i = 1'b1;
        #1;
        chk("mti_redirect", 32'(redirect_o), 32'h1);
        chk("mti_vector", redirect_pc_o, 32'h11C);
        step();
        t_intr_i = 1'b0; intr_ready_i = 1'b0;
        rd(12'h341); chk("mti_mepc", d, 32'h200);
        rd(12'h342); chk("mti_mcause", d, 32'h8000_0007);
        rd(12'h300); chk("mti_mstatus", d, 32'h1880);
        csr(3'b001, 12'h304, 32'h880);
        csr(3'b010, 12'h300, 32'h8);
        rd(12'h300); chk("mie_reenable", d, 32'h1888);
        t_intr_i = 1'b1; e_intr_i = 1'b1; intr_ready_i = 1'b1; pc_i = 32'h300;
        #1;
        chk("mei_vector", redirect_pc_o, 32'h12C);
        step();
        t_intr_i = 1'b0; e_intr_i = 1'b0; intr_ready_i = 1'b0;
        rd(12'h342); chk("mei_mcause", d, 32'h8000_000B);
        mret_i = 1'b1;
        #1;
        chk("mret_redirect", 32'(redirect_o), 32'h1);
        chk("mret_pc", redirect_pc_o, 32'h300);
        step();
        mret_i = 1'b0;
        rd(12'h300); chk("mret_mstatus", d, 32'h1888);
        t_intr_i = 1'b1; intr_ready_i = 1'b1; mret_i = 1'b1; pc_i = 32'h400;
        bus.valid = 1'b1; bus.op = 3'b001; bus.addr = 12'h340; bus.wdata = 32'h1234;
        #1;
        chk("simul_vector", redirect_pc_o, 32'h11C);
        step();
        bus.valid = 1'b0; t_intr_i = 1'b0; intr_ready_i = 1'b0; mret_i = 1'b0;
        rd(12'h340); chk("simul_mscratch", d, 32'hDEAD_BEEF);
        rd(12'h341); chk("simul_mepc", d, 32'h400);
        rd(12'h300); chk("simul_mstatus", d, 32'h1880);
        csr(3'b001, 12'hB80, 32'h0);
        csr(3'b001, 12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00); chk("mcycle_max", d, 32'hFFFF_FFFF);
        rd(12'hB00); chk("mcycle_wrap_lo", d, 32'h0);
        rd(12'hB80); chk("mcycle_wrap_hi", d, 32'h1);
        csr(3'b001, 12'hB00, 32'h5);
        rd(12'hB00); chk("mcycle_write", d, 32'h5);
        retire_i = 1'b1;
        csr(3'b001, 12'hB02, 32'hA);
        rd(12'hB02); chk("minstret_write", d, 32'hA);
        retire_i = 1'b0;
        rd(12'hB02); chk("minstret_inc", d, 32'hB);
        bus.valid = 1'b1; bus.op = 3'b001; bus.addr = 12'h340; bus.wdata = 32'h5555;
        #2 rst_i = 1'b1;
        #1 rst_i = 1'b0;
        bus.valid = 1'b0;
        rd(12'h340); chk("midrst_mscratch", d, 32'h0);
        rd(12'h305); chk("midrst_mtvec", d, 32'h40);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
